pio_clkdiv_sched: RTL and testbench

Fractional clock-enable scheduler for the four PIO state machines. It converts each SM's SMx_CLKDIV setting (16-bit integer, 8-bit fraction), together with the CTRL enable and restart bits from the control register file, into one-cycle `clk_en` pulses. Each SM advances only on cycles where its `clk_en` bit is high. The block sits between `control_regfile` and the SM cores.

---
 rtl/pio_pkg.sv | 24 ++
 rtl/pio_clkdiv_chan.sv | 67 ++++++
 rtl/pio_clkdiv_sched.sv | 27 ++
 tb/tb_pio_clkdiv_sched.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared PIO definitions: divider field widths, the CLKDIV struct used by the
// control register file repacking, and the effective-integer helper.
package pio_pkg;

   localparam int N_SM          = 4;
   localparam int CLKDIV_INT_W  = 16;
   localparam int CLKDIV_FRAC_W = 8;
   localparam int CNT_W         = CLKDIV_INT_W + 1;

   typedef struct packed {
      logic [CLKDIV_INT_W-1:0]  int_div;
      logic [CLKDIV_FRAC_W-1:0] frac;
   } clkdiv_t;

   // An integer field of zero encodes the maximum divisor of 2^INT_W.
   function automatic logic [CNT_W-1:0] int_eff(input logic [CLKDIV_INT_W-1:0] int_div);
      if (int_div == {CLKDIV_INT_W{1'b0}}) begin
         return {1'b1, {CLKDIV_INT_W{1'b0}}};
      end else begin
         return {1'b0, int_div};
      end
   endfunction

endpackage

// File: rtl/pio_clkdiv_chan.sv
// One fractional clock-enable channel: interval counter plus fractional
// accumulator whose carry stretches an interval by one cycle.
module pio_clkdiv_chan
   import pio_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    sm_en_i,
   input  logic    restart_i,
   input  clkdiv_t clkdiv_i,
   output logic    clk_en_o,
   output logic    running_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [CLKDIV_FRAC_W-1:0] facc_q, facc_d;
   logic                     clk_en_q, clk_en_d;
   logic                     running_q, running_d;
   logic [CLKDIV_FRAC_W:0]   facc_sum_s;
   logic [CNT_W-1:0]         reload_s;

   assign facc_sum_s = {1'b0, facc_q} + {1'b0, clkdiv_i.frac};
   assign reload_s   = int_eff(clkdiv_i.int_div)
                     + {{(CNT_W-1){1'b0}}, facc_sum_s[CLKDIV_FRAC_W]};

   // Next-state selection: restart beats hold, hold beats tick/count.
   always_comb begin
      cnt_d     = cnt_q;
      facc_d    = facc_q;
      clk_en_d  = 1'b0;
      running_d = sm_en_i & ~restart_i;
      if (restart_i) begin
         cnt_d  = CNT_ONE;
         facc_d = {CLKDIV_FRAC_W{1'b0}};
      end else if (!sm_en_i) begin
         cnt_d  = cnt_q;
         facc_d = facc_q;
      end else if (cnt_q == CNT_ONE) begin
         clk_en_d = 1'b1;
         facc_d   = facc_sum_s[CLKDIV_FRAC_W-1:0];
         cnt_d    = reload_s;
      end else begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   // State and output registers; reset leaves cnt at 1 so the first enabled cycle ticks.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q     <= CNT_ONE;
         facc_q    <= {CLKDIV_FRAC_W{1'b0}};
         clk_en_q  <= 1'b0;
         running_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         facc_q    <= facc_d;
         clk_en_q  <= clk_en_d;
         running_q <= running_d;
      end
   end

   assign clk_en_o  = clk_en_q;
   assign running_o = running_q;

endmodule

// File: rtl/pio_clkdiv_sched.sv
// Clock-enable scheduler for the PIO state machines: independent fractional
// divider channels, one per SM, with no shared state.
module pio_clkdiv_sched
   import pio_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [N_SM-1:0]    sm_en_i,
   input  logic [N_SM-1:0]    clkdiv_restart_i,
   input  clkdiv_t [N_SM-1:0] clkdiv_i,
   output logic [N_SM-1:0]    clk_en_o,
   output logic [N_SM-1:0]    running_o
);

   for (genvar g = 0; g < N_SM; g++) begin : g_chan
      pio_clkdiv_chan u_chan (
         .clk       (clk),
         .rst       (rst),
         .sm_en_i   (sm_en_i[g]),
         .restart_i (clkdiv_restart_i[g]),
         .clkdiv_i  (clkdiv_i[g]),
         .clk_en_o  (clk_en_o[g]),
         .running_o (running_o[g])
      );
   end

endmodule

// File: tb/tb_pio_clkdiv_sched.sv
// Self-checking bench for pio_clkdiv_sched: directed scenarios plus random
// traffic, compared against a fixed-point tick-schedule model.
module tb_pio_clkdiv_sched;
   import pio_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [N_SM-1:0]    sm_en;
   logic [N_SM-1:0]    restart;
   clkdiv_t [N_SM-1:0] clkdiv;
   logic [N_SM-1:0]    clk_en;
   logic [N_SM-1:0]    running;

   int tests = 0;
   int fails = 0;

   // Model: each channel ticks on enabled cycle m_c whenever m_c equals the
   // integer part of the scheduled tick time m_t (units of 1/256 cycle).
   longint          m_c [N_SM];
   longint          m_t [N_SM];
   logic [N_SM-1:0] exp_en;
   logic [N_SM-1:0] exp_run;

   pio_clkdiv_sched dut (
      .clk              (clk),
      .rst              (rst),
      .sm_en_i          (sm_en),
      .clkdiv_restart_i (restart),
      .clkdiv_i         (clkdiv),
      .clk_en_o         (clk_en),
      .running_o        (running)
   );

   always #5 clk = ~clk;

   function automatic clkdiv_t mk(input int i, input int f);
      clkdiv_t d;
      d.int_div = i[15:0];
      d.frac    = f[7:0];
      return d;
   endfunction

   function automatic longint d256(input clkdiv_t d);
      longint ip;
      ip = (d.int_div == 16'd0) ? 64'd65536 : longint'(d.int_div);
      return ip * 256 + longint'(d.frac);
   endfunction

   task automatic check_vec(input string tag, input logic [N_SM-1:0] obs, input logic [N_SM-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N_SM; i++) begin
         m_c[i] = 0;
         m_t[i] = 0;
      end
      exp_en  = '0;
      exp_run = '0;
   endtask

   task automatic model_cycle();
      for (int i = 0; i < N_SM; i++) begin
         exp_run[i] = sm_en[i] & ~restart[i];
         exp_en[i]  = 1'b0;
         if (restart[i]) begin
            m_c[i] = 0;
            m_t[i] = 0;
         end else if (sm_en[i]) begin
            if (m_c[i] == (m_t[i] >>> 8)) begin
               exp_en[i] = 1'b1;
               m_t[i]    = m_t[i] + d256(clkdiv[i]);
            end
            m_c[i] = m_c[i] + 1;
         end
      end
   endtask

   task automatic step();
      model_cycle();
      @(posedge clk);
      #1;
      check_vec("clk_en", clk_en, exp_en);
      check_vec("running", running, exp_run);
   endtask

   task automatic wait_tick(input int ch, input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (clk_en[ch] !== 1'b1 && n < limit);
      tests++;
      assert (clk_en[ch] === 1'b1) else begin
         fails++;
         $error("FAIL tick_timeout ch%0d observed=%b expected=1 after %0d cycles", ch, clk_en[ch], n);
      end
   endtask

   task automatic pulse_restart(input logic [N_SM-1:0] mask);
      restart = mask;
      step();
      restart = '0;
   endtask

   initial begin
      int n, gap, ticks;
      rst     = 1'b1;
      sm_en   = '0;
      restart = '0;
      for (int i = 0; i < N_SM; i++) clkdiv[i] = mk(1, 0);
      model_reset();
      #1;
      check_vec("reset_clk_en", clk_en, 4'b0000);
      check_vec("reset_running", running, 4'b0000);

      // Divide by 1: every cycle ticks from the first post-release edge.
      sm_en = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      check_vec("first_tick_after_reset", clk_en, 4'hF);
      repeat (20) step();

      // D = 2.5 on SM0: 512 ticks in 1280 cycles after restart.
      clkdiv[0] = mk(2, 8'h80);
      pulse_restart(4'b0001);
      ticks = 0;
      for (int k = 0; k < 1280; k++) begin
         step();
         if (clk_en[0] === 1'b1) ticks++;
      end
      check_int("d2p5_tick_count", ticks, 512);

      // D = 8 changed to D = 2 mid-interval on SM1.
      clkdiv[1] = mk(8, 0);
      pulse_restart(4'b0010);
      wait_tick(1, 4, n);
      check_int("d8_first_tick_latency", n, 1);
      repeat (3) step();
      clkdiv[1] = mk(2, 0);
      wait_tick(1, 20, n);
      check_int("d8_interval_kept", n + 3, 8);
      wait_tick(1, 20, n);
      check_int("d2_interval_a", n, 2);
      wait_tick(1, 20, n);
      check_int("d2_interval_b", n, 2);

      // D = 4 on SM2 with a 10-cycle disable one cycle after a tick.
      clkdiv[2] = mk(4, 0);
      pulse_restart(4'b0100);
      wait_tick(2, 4, n);
      step();
      sm_en[2] = 1'b0;
      repeat (10) step();
      sm_en[2] = 1'b1;
      wait_tick(2, 40, n);
      check_int("resume_enabled_cycles", n, 3);
      check_int("resume_wallclock_gap", 1 + 10 + n, 14);

      // Phase alignment of SM0/SM1 at D = 3.
      clkdiv[0] = mk(3, 0);
      clkdiv[1] = mk(3, 0);
      pulse_restart(4'b0001);
      step();
      pulse_restart(4'b0010);
      repeat (5) step();
      pulse_restart(4'b0011);
      for (int k = 0; k < 1000; k++) begin
         step();
         if (clk_en[0] !== clk_en[1]) begin
            check_vec("phase_aligned", {3'b000, clk_en[1]}, {3'b000, clk_en[0]});
         end
      end
      check_int("phase_aligned_tick_count_k", m_c[0], m_c[1]);

      // Restart while disabled stays silent.
      sm_en[3] = 1'b0;
      pulse_restart(4'b1000);
      repeat (5) step();
      check_vec("restart_disabled_quiet", {3'b000, clk_en[3]}, 4'b0000);
      sm_en[3] = 1'b1;

      // Random traffic: enables, restarts and divisor rewrites.
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < N_SM; i++) begin
            if ($urandom_range(0, 99) < 3) clkdiv[i] = mk($urandom_range(1, 6), $urandom_range(0, 255));
            if ($urandom_range(0, 99) < 5) sm_en[i] = ~sm_en[i];
            restart[i] = ($urandom_range(0, 99) < 2);
         end
         step();
      end
      restart = '0;
      sm_en   = 4'hF;

      // Asynchronous reset mid-interval.
      for (int i = 0; i < N_SM; i++) clkdiv[i] = mk(5, 0);
      repeat (7) step();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_vec("async_reset_clk_en", clk_en, 4'b0000);
      check_vec("async_reset_running", running, 4'b0000);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      check_vec("tick_after_reset_release", clk_en, 4'hF);

      // INT = 0 means 65536-cycle interval.
      clkdiv[0] = mk(0, 0);
      pulse_restart(4'b0001);
      wait_tick(0, 4, n);
      check_int("int0_first_tick", n, 1);
      wait_tick(0, 70000, n);
      check_int("int0_interval", n, 65536);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
